// File: rtl/semester_judge.sv
// Semester accumulator and verdict FSM. It takes one day result per valid/ready accept.
// Done rises 2 cycles after the final accept (1 on expulsion); day_ready is low outside RUN.
module semester_judge #(
    parameter int NUM_DAYS    = 8,
    parameter int PASS_NEEDED = 5,
    parameter int MAX_STREAK  = 3,
    parameter int CREDIT_XCHG = 4,
    parameter int CNT_W       = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             day_valid_i,
    output logic             day_ready_o,
    input  logic             pass_day_i,
    input  logic [1:0]       bonus_day_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             graduate_o,
    output logic             expelled_o,
    output logic [CNT_W-1:0] day_cnt_o,
    output logic [CNT_W-1:0] pass_cnt_o,
    output logic [3:0]       credits_o
);

    typedef enum logic [1:0] {IDLE, RUN, JUDGE, DONE} state_t;

    localparam int EW = CNT_W + 3;
    localparam logic [CNT_W-1:0] NUM_DAYS_C   = CNT_W'(NUM_DAYS);
    localparam logic [CNT_W-1:0] MAX_STREAK_C = CNT_W'(MAX_STREAK);
    localparam logic [EW-1:0]    PASS_NEED_C  = EW'(PASS_NEEDED);
    localparam logic [EW-1:0]    XCHG_C       = EW'(CREDIT_XCHG);

    state_t           state_q;
    logic [CNT_W-1:0] day_cnt_q, pass_cnt_q, streak_q;
    logic [3:0]       credits_q;
    logic             done_q, graduate_q, expelled_q;

    logic             accept;
    logic [CNT_W-1:0] day_cnt_d, pass_cnt_d, streak_d;
    logic [3:0]       credits_d;
    logic [4:0]       credit_sum;
    logic [EW-1:0]    eff;

    assign day_ready_o = (state_q == RUN);
    assign busy_o      = (state_q == RUN) || (state_q == JUDGE);
    assign accept      = day_valid_i && day_ready_o;

    // A failed day leaves credits untouched and ignores its bonus.
    assign credit_sum  = {1'b0, credits_q} + {3'b000, bonus_day_i};
    assign day_cnt_d   = day_cnt_q + 1'b1;
    assign pass_cnt_d  = pass_day_i ? pass_cnt_q + 1'b1 : pass_cnt_q;
    assign streak_d    = pass_day_i ? '0 : streak_q + 1'b1;
    assign credits_d   = pass_day_i ? (credit_sum[4] ? 4'hF : credit_sum[3:0]) : credits_q;
    assign eff         = EW'(pass_cnt_q) + EW'(credits_q) / XCHG_C;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            day_cnt_q  <= '0;
            pass_cnt_q <= '0;
            streak_q   <= '0;
            credits_q  <= '0;
            done_q     <= 1'b0;
            graduate_q <= 1'b0;
            expelled_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start_i) begin
                        state_q    <= RUN;
                        day_cnt_q  <= '0;
                        pass_cnt_q <= '0;
                        streak_q   <= '0;
                        credits_q  <= '0;
                        done_q     <= 1'b0;
                        graduate_q <= 1'b0;
                        expelled_q <= 1'b0;
                    end
                end
                RUN: begin
                    if (accept) begin
                        day_cnt_q  <= day_cnt_d;
                        pass_cnt_q <= pass_cnt_d;
                        streak_q   <= streak_d;
                        credits_q  <= credits_d;
                        // Expulsion wins even on the last day of the semester.
                        if (streak_d == MAX_STREAK_C) begin
                            state_q    <= DONE;
                            done_q     <= 1'b1;
                            expelled_q <= 1'b1;
                            graduate_q <= 1'b0;
                        end else if (day_cnt_d == NUM_DAYS_C) begin
                            state_q <= JUDGE;
                        end
                    end
                end
                JUDGE: begin
                    graduate_q <= (eff >= PASS_NEED_C);
                    expelled_q <= 1'b0;
                    done_q     <= 1'b1;
                    state_q    <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign done_o     = done_q;
    assign graduate_o = graduate_q;
    assign expelled_o = expelled_q;
    assign day_cnt_o  = day_cnt_q;
    assign pass_cnt_o = pass_cnt_q;
    assign credits_o  = credits_q;

endmodule

// File: tb/tb_semester_judge.sv
// Directed bench for semester_judge: a scoreboard of expected verdicts checked on each done rise.
module tb_semester_judge;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       day_valid = 1'b0;
    logic       day_ready;
    logic       pass_day = 1'b0;
    logic [1:0] bonus_day = 2'd0;
    logic       busy, done, graduate, expelled;
    logic [3:0] day_cnt, pass_cnt, credits;

    semester_judge dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .start_i     (start),
        .day_valid_i (day_valid),
        .day_ready_o (day_ready),
        .pass_day_i  (pass_day),
        .bonus_day_i (bonus_day),
        .busy_o      (busy),
        .done_o      (done),
        .graduate_o  (graduate),
        .expelled_o  (expelled),
        .day_cnt_o   (day_cnt),
        .pass_cnt_o  (pass_cnt),
        .credits_o   (credits)
    );

    always #5 clk = ~clk;

    typedef struct {
        int g;
        int e;
        int d;
        int p;
        int c;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   last_acc = 0;
    bit   done_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, int act, int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endfunction

    // Monitor: every rising edge of done must match the oldest queued verdict.
    always @(negedge clk) begin
        if (done && !done_prev) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t x;
                x = sb.pop_front();
                chk("graduate", int'(graduate), x.g);
                chk("expelled", int'(expelled), x.e);
                chk("day_cnt", int'(day_cnt), x.d);
                chk("pass_cnt", int'(pass_cnt), x.p);
                chk("credits", int'(credits), x.c);
                chk("done_cycle", cyc, x.cyc);
            end
        end
        done_prev = done;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_sem();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic day(input bit p, input logic [1:0] b);
        int n = 0;
        day_valid = 1'b1;
        pass_day  = p;
        bonus_day = b;
        while (!day_ready && n < 20) begin
            tick();
            n++;
        end
        if (!day_ready) chk("ready_timeout", 0, 1);
        last_acc = cyc;
        tick();
        day_valid = 1'b0;
    endtask

    task automatic expect_verdict(input int g, input int e, input int d, input int p, input int c);
        exp_t x;
        x.g = g; x.e = e; x.d = d; x.p = p; x.c = c;
        x.cyc = last_acc + (e != 0 ? 1 : 2);
        sb.push_back(x);
    endtask

    task automatic wait_verdict();
        int n = 0;
        while (sb.size() != 0 && n < 10) begin
            tick();
            n++;
        end
        chk("verdict_pending", sb.size(), 0);
        sb.delete();
    endtask

    task automatic run_days(input string pat, input int bonus);
        for (int i = 0; i < pat.len(); i++)
            day(pat[i] == "P", 2'(bonus));
    endtask

    initial begin
        repeat (3) tick();
        rst = 1'b0;
        // Reset state
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(day_ready), 0);
        chk("rst_day_cnt", int'(day_cnt), 0);

        // T1: eight passes, no bonus
        start_sem();
        chk("t1_busy", int'(busy), 1);
        run_days("PPPPPPPP", 0);
        expect_verdict(1, 0, 8, 8, 0);
        wait_verdict();

        // T2: P,F,F,F -> expelled on the 4th day
        start_sem();
        run_days("PFFF", 0);
        expect_verdict(0, 1, 4, 1, 0);
        wait_verdict();

        // T3: alternating F/P with bonus 2 on every day (bonus ignored on fails)
        start_sem();
        run_days("FPFPFPFP", 2);
        expect_verdict(1, 0, 8, 4, 8);
        wait_verdict();

        // Judgement boundary: 4 passes + 3 credits -> eff 4 < 5
        start_sem();
        day(1'b1, 2'd3);
        run_days("PPFFPFF", 0);
        expect_verdict(0, 0, 8, 4, 3);
        wait_verdict();

        // T4: five passes at bonus 3, then three fails ending on day 8
        start_sem();
        run_days("PPPPPFFF", 3);
        expect_verdict(0, 1, 8, 5, 15);
        wait_verdict();

        // T6: start from DONE clears everything on the same edge
        start_sem();
        chk("t6_done", int'(done), 0);
        chk("t6_expelled", int'(expelled), 0);
        chk("t6_day_cnt", int'(day_cnt), 0);
        chk("t6_pass_cnt", int'(pass_cnt), 0);
        chk("t6_credits", int'(credits), 0);
        chk("t6_busy", int'(busy), 1);
        // Six passes at bonus 3 saturate credits at 15; eff = 6 + 3
        run_days("PPPPPPFF", 3);
        expect_verdict(1, 0, 8, 6, 15);
        wait_verdict();

        // T5: gaps, start ignored mid-RUN, reset aborts the semester
        start_sem();
        day(1'b1, 2'd1);
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t5_start_ignored", int'(day_cnt), 1);
        chk("t5_busy", int'(busy), 1);
        day(1'b0, 2'd2);
        tick();
        day(1'b1, 2'd1);
        chk("t5_day_cnt", int'(day_cnt), 3);
        chk("t5_pass_cnt", int'(pass_cnt), 2);
        chk("t5_credits", int'(credits), 2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5_rst_day_cnt", int'(day_cnt), 0);
        chk("t5_rst_pass_cnt", int'(pass_cnt), 0);
        chk("t5_rst_credits", int'(credits), 0);
        chk("t5_rst_busy", int'(busy), 0);
        chk("t5_rst_done", int'(done), 0);
        // Valid held in IDLE must be ignored
        day_valid = 1'b1;
        pass_day  = 1'b1;
        repeat (3) tick();
        day_valid = 1'b0;
        chk("idle_ready", int'(day_ready), 0);
        chk("idle_day_cnt", int'(day_cnt), 0);
        repeat (5) tick();
        chk("t5_no_done", int'(done), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
